// File: rtl/cfg_mgmt_pkg.sv
// Shared widths, request record and FSM encoding for the cfg_mgmt arbiter slice.
package cfg_mgmt_pkg;

  localparam int CFG_ADDR_W = 10;
  localparam int CFG_FN_W   = 16;
  localparam int CFG_DATA_W = 32;
  localparam int CFG_BE_W   = 4;

  typedef struct packed {
    logic                  write;
    logic [CFG_ADDR_W-1:0] addr;
    logic [CFG_FN_W-1:0]   function_number;
    logic [CFG_DATA_W-1:0] write_data;
    logic [CFG_BE_W-1:0]   byte_enable;
  } cfg_mgmt_req_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  // Read data returned to a requester whose access was aborted.
  localparam logic [CFG_DATA_W-1:0] CFG_TIMEOUT_RDATA = 32'hFFFF_FFFF;

endpackage

// File: rtl/cfg_mgmt_arbiter_if.sv
// PCIe core cfg_mgmt port. master = arbiter side (drives the command), slave = core side.
// Handshake: the command (read or write plus fields) stays asserted and stable until the
// core pulses cfg_mgmt_read_write_done for one cycle; read data is valid in that cycle.
interface cfg_mgmt_arbiter_if;
  import cfg_mgmt_pkg::*;

  logic [CFG_ADDR_W-1:0] cfg_mgmt_addr;
  logic [CFG_FN_W-1:0]   cfg_mgmt_function_number;
  logic                  cfg_mgmt_write;
  logic [CFG_DATA_W-1:0] cfg_mgmt_write_data;
  logic [CFG_BE_W-1:0]   cfg_mgmt_byte_enable;
  logic                  cfg_mgmt_read;
  logic                  cfg_mgmt_debug_access;
  logic [CFG_DATA_W-1:0] cfg_mgmt_read_data;
  logic                  cfg_mgmt_read_write_done;

  modport master (
    output cfg_mgmt_addr, cfg_mgmt_function_number, cfg_mgmt_write, cfg_mgmt_write_data,
           cfg_mgmt_byte_enable, cfg_mgmt_read, cfg_mgmt_debug_access,
    input  cfg_mgmt_read_data, cfg_mgmt_read_write_done
  );

  modport slave (
    input  cfg_mgmt_addr, cfg_mgmt_function_number, cfg_mgmt_write, cfg_mgmt_write_data,
           cfg_mgmt_byte_enable, cfg_mgmt_read, cfg_mgmt_debug_access,
    output cfg_mgmt_read_data, cfg_mgmt_read_write_done
  );

endinterface

// File: rtl/rr_arbiter_onehot.sv
// Combinational round-robin pick: first asserted request after index 'last', wrapping.
module rr_arbiter_onehot #(
  parameter int N = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic found;
  int   j;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int i = 1; i <= N; i++) begin
      j = (int'(last) + i) % N;
      if (!found && req[j[IW-1:0]]) begin
        found            = 1'b1;
        gnt[j[IW-1:0]]   = 1'b1;
        idx              = IW'(j);
      end
    end
  end

endmodule

// File: rtl/cfg_mgmt_arbiter.sv
// Shares the PCIe core cfg_mgmt port between NUM_REQ requesters, round-robin.
// Optional access timeout: define CFG_MGMT_ARB_TIMEOUT_EN.
module cfg_mgmt_arbiter
  import cfg_mgmt_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                           user_clk,
  input  logic                           user_reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_write,
  input  logic [NUM_REQ*CFG_ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ*CFG_FN_W-1:0]    req_function_number,
  input  logic [NUM_REQ*CFG_DATA_W-1:0]  req_write_data,
  input  logic [NUM_REQ*CFG_BE_W-1:0]    req_byte_enable,
  output logic [NUM_REQ-1:0]             req_done,
  output logic [CFG_DATA_W-1:0]          req_read_data,
  output logic                           req_error,
  output logic [NUM_REQ-1:0]             grant,
  cfg_mgmt_arbiter_if.master             cfg,
  output arb_state_t                     state_dbg
);

  localparam int IW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("cfg_mgmt_arbiter: NUM_REQ must be in 2..8");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("cfg_mgmt_arbiter: TIMEOUT_CYCLES must be at least 2");
  end

  arb_state_t           state_q, state_n;
  logic [IW-1:0]        rr_ptr_q, rr_ptr_n;
  logic [NUM_REQ-1:0]   grant_q, grant_n;
  logic                 act_q, act_n;
  cfg_mgmt_req_t        cmd_q, cmd_n;
  logic [NUM_REQ-1:0]   done_q, done_n;
  logic [CFG_DATA_W-1:0] rdata_q, rdata_n;
  logic                 err_q, err_n;

`ifdef CFG_MGMT_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  logic [CNT_W-1:0]     cnt_q, cnt_n;
`endif

  logic [NUM_REQ-1:0]   win_gnt;
  logic [IW-1:0]        win_idx;
  cfg_mgmt_req_t        win_req;

  rr_arbiter_onehot #(.N(NUM_REQ)) u_rr (
    .req  (req_valid),
    .last (rr_ptr_q),
    .gnt  (win_gnt),
    .idx  (win_idx)
  );

  // Fields are taken from the winner only at grant time; later changes are ignored.
  always_comb begin
    win_req.write           = req_write[win_idx];
    win_req.addr            = req_addr[win_idx*CFG_ADDR_W +: CFG_ADDR_W];
    win_req.function_number = req_function_number[win_idx*CFG_FN_W +: CFG_FN_W];
    win_req.write_data      = req_write_data[win_idx*CFG_DATA_W +: CFG_DATA_W];
    win_req.byte_enable     = req_byte_enable[win_idx*CFG_BE_W +: CFG_BE_W];
  end

  always_comb begin
    state_n  = state_q;
    rr_ptr_n = rr_ptr_q;
    grant_n  = grant_q;
    act_n    = act_q;
    cmd_n    = cmd_q;
    done_n   = '0;
    rdata_n  = '0;
    err_n    = 1'b0;
`ifdef CFG_MGMT_ARB_TIMEOUT_EN
    cnt_n    = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          grant_n  = win_gnt;
          rr_ptr_n = win_idx;
          cmd_n    = win_req;
          act_n    = 1'b1;
          state_n  = ACCESS;
`ifdef CFG_MGMT_ARB_TIMEOUT_EN
          cnt_n    = '0;
`endif
        end
      end
      ACCESS: begin
`ifdef CFG_MGMT_ARB_TIMEOUT_EN
        cnt_n = cnt_q + 1'b1;
`endif
        if (cfg.cfg_mgmt_read_write_done) begin
          act_n   = 1'b0;
          cmd_n   = '0;
          done_n  = grant_q;
          rdata_n = cmd_q.write ? '0 : cfg.cfg_mgmt_read_data;
          state_n = RESP;
        end
`ifdef CFG_MGMT_ARB_TIMEOUT_EN
        // A done in the expiry cycle takes the branch above and completes normally.
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          act_n   = 1'b0;
          cmd_n   = '0;
          done_n  = grant_q;
          rdata_n = CFG_TIMEOUT_RDATA;
          err_n   = 1'b1;
          state_n = RESP;
        end
`endif
      end
      RESP: begin
        grant_n = '0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= IW'(NUM_REQ - 1);
      grant_q  <= '0;
      act_q    <= 1'b0;
      cmd_q    <= '0;
      done_q   <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
`ifdef CFG_MGMT_ARB_TIMEOUT_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_n;
      rr_ptr_q <= rr_ptr_n;
      grant_q  <= grant_n;
      act_q    <= act_n;
      cmd_q    <= cmd_n;
      done_q   <= done_n;
      rdata_q  <= rdata_n;
      err_q    <= err_n;
`ifdef CFG_MGMT_ARB_TIMEOUT_EN
      cnt_q    <= cnt_n;
`endif
    end
  end

  assign req_done                     = done_q;
  assign req_read_data                = rdata_q;
`ifdef CFG_MGMT_ARB_TIMEOUT_EN
  assign req_error                    = err_q;
`else
  assign req_error                    = 1'b0;
`endif
  assign grant                        = grant_q;
  assign state_dbg                    = state_q;
  assign cfg.cfg_mgmt_addr            = cmd_q.addr;
  assign cfg.cfg_mgmt_function_number = cmd_q.function_number;
  assign cfg.cfg_mgmt_write_data      = cmd_q.write_data;
  assign cfg.cfg_mgmt_byte_enable     = cmd_q.byte_enable;
  assign cfg.cfg_mgmt_write           = act_q & cmd_q.write;
  assign cfg.cfg_mgmt_read            = act_q & ~cmd_q.write;
  assign cfg.cfg_mgmt_debug_access    = 1'b0;

endmodule

// File: tb/tb_cfg_mgmt_arbiter.sv
// Bench for cfg_mgmt_arbiter: table-driven accesses with a done-ordered scoreboard,
// plus contention, reset-mid-access, round-robin wrap and (with the macro) timeout sequences.
module tb_cfg_mgmt_arbiter;
  import cfg_mgmt_pkg::*;

  localparam int TO    = 16;
  localparam int EXP_W = 2 + 1 + 32 + 8 + 1;

  // ---------------- clock / reset ----------------
  logic user_clk = 1'b0;
  logic user_reset = 1'b1;
  always #5 user_clk = ~user_clk;

  // ---------------- DUT0: two requesters ----------------
  logic [1:0]  req_valid = '0, req_write = '0;
  logic [19:0] req_addr = '0;
  logic [31:0] req_fn = '0;
  logic [63:0] req_wdata = '0;
  logic [7:0]  req_be = '0;
  logic [1:0]  req_done, grant;
  logic [31:0] req_read_data;
  logic        req_error;
  arb_state_t  state0;
  cfg_mgmt_arbiter_if if0();

  cfg_mgmt_arbiter #(.NUM_REQ(2), .TIMEOUT_CYCLES(TO)) dut0 (
    .user_clk(user_clk), .user_reset(user_reset), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_function_number(req_fn), .req_write_data(req_wdata),
    .req_byte_enable(req_be), .req_done(req_done), .req_read_data(req_read_data),
    .req_error(req_error), .grant(grant), .cfg(if0), .state_dbg(state0)
  );

  // ---------------- DUT1: three requesters for wrap ----------------
  logic [2:0]  v1 = '0, w1 = '0;
  logic [29:0] a1 = '0;
  logic [47:0] f1 = '0;
  logic [95:0] d1 = '0;
  logic [11:0] b1 = '0;
  logic [2:0]  done1, grant1;
  logic [31:0] rdata1;
  logic        err1;
  arb_state_t  state1;
  cfg_mgmt_arbiter_if if1();

  cfg_mgmt_arbiter #(.NUM_REQ(3), .TIMEOUT_CYCLES(TO)) dut1 (
    .user_clk(user_clk), .user_reset(user_reset), .req_valid(v1), .req_write(w1),
    .req_addr(a1), .req_function_number(f1), .req_write_data(d1), .req_byte_enable(b1),
    .req_done(done1), .req_read_data(rdata1), .req_error(err1), .grant(grant1),
    .cfg(if1), .state_dbg(state1)
  );

  // ---------------- scoreboard / counters ----------------
  int total = 0;
  int bad = 0;
  logic [EXP_W-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [EXP_W-1:0] pack_exp(input logic [1:0] vec, input logic err,
                                                 input logic [31:0] rd, input int len,
                                                 input logic w);
    return {vec, err, rd, 8'(len), w};
  endfunction

  // ---------------- core models ----------------
  logic        core_en = 1'b1;
  int          core_lat = 1;
  logic [31:0] core_rdata = '0;
  logic        stray_done = 1'b0;

  initial begin
    int   cnt;
    logic d;
    cnt = 0;
    if0.cfg_mgmt_read_write_done = 1'b0;
    if0.cfg_mgmt_read_data = '0;
    forever begin
      @(negedge user_clk);
      if (if0.cfg_mgmt_read || if0.cfg_mgmt_write) cnt++;
      else cnt = 0;
      d = core_en && (cnt == core_lat);
      if0.cfg_mgmt_read_write_done = d | stray_done;
      if0.cfg_mgmt_read_data = d ? core_rdata : $urandom;
    end
  end

  initial begin
    int cnt;
    cnt = 0;
    if1.cfg_mgmt_read_write_done = 1'b0;
    if1.cfg_mgmt_read_data = '0;
    forever begin
      @(negedge user_clk);
      if (if1.cfg_mgmt_read || if1.cfg_mgmt_write) cnt++;
      else cnt = 0;
      if1.cfg_mgmt_read_write_done = (cnt == 2);
    end
  end

  // ---------------- DUT0 monitor ----------------
  int done_cnt = 0;
  initial begin
    int cmd_len, gap;
    logic have_prev, saw_rd, saw_wr, stable;
    logic [9:0] c_addr; logic [15:0] c_fn; logic [31:0] c_wd; logic [3:0] c_be;
    logic [EXP_W-1:0] e;
    cmd_len = 0; gap = 0; have_prev = 0; saw_rd = 0; saw_wr = 0; stable = 1;
    c_addr = '0; c_fn = '0; c_wd = '0; c_be = '0;
    forever begin
      @(negedge user_clk);
      if (user_reset) begin
        cmd_len = 0; gap = 0; have_prev = 0; saw_rd = 0; saw_wr = 0; stable = 1;
      end else begin
        if (if0.cfg_mgmt_read || if0.cfg_mgmt_write) begin
          if (cmd_len == 0) begin
            if (have_prev) check("cmd_gap", 64'(gap >= 1), 1);
            c_addr = if0.cfg_mgmt_addr; c_fn = if0.cfg_mgmt_function_number;
            c_wd = if0.cfg_mgmt_write_data; c_be = if0.cfg_mgmt_byte_enable;
          end else if (c_addr !== if0.cfg_mgmt_addr || c_fn !== if0.cfg_mgmt_function_number ||
                       c_wd !== if0.cfg_mgmt_write_data || c_be !== if0.cfg_mgmt_byte_enable) begin
            stable = 0;
          end
          cmd_len++;
          saw_rd |= if0.cfg_mgmt_read;
          saw_wr |= if0.cfg_mgmt_write;
        end else begin
          gap++;
        end
        if (req_done != 0) begin
          done_cnt++;
          if (exp_q.size() == 0) begin
            check("unexpected_done", 64'(req_done), 0);
          end else begin
            e = exp_q.pop_front();
            check("done_vec", 64'(req_done), 64'(e[EXP_W-1 -: 2]));
            check("done_err", 64'(req_error), 64'(e[EXP_W-3]));
            check("done_rdata", 64'(req_read_data), 64'(e[40:9]));
            check("cmd_len", 64'(cmd_len), 64'(e[8:1]));
            check("cmd_kind", 64'({saw_wr, saw_rd}), 64'({e[0], ~e[0]}));
            check("cmd_stable", 64'(stable), 1);
          end
          cmd_len = 0; saw_rd = 0; saw_wr = 0; stable = 1; have_prev = 1; gap = 0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  typedef struct {
    int          idx;
    logic        w;
    logic [9:0]  addr;
    logic [15:0] fn;
    logic [31:0] wd;
    logic [3:0]  be;
    int          lat;
    logic [31:0] rd;
    logic        drop_early;
    logic [31:0] exp_rdata;
  } vec_t;

  task automatic do_reset();
    user_reset = 1'b1;
    req_valid = '0;
    v1 = '0;
    repeat (2) @(negedge user_clk);
    user_reset = 1'b0;
    @(negedge user_clk);
  endtask

  task automatic set_fields(input int idx, input logic w, input logic [9:0] addr,
                            input logic [15:0] fn, input logic [31:0] wd, input logic [3:0] be);
    req_write[idx] = w;
    req_addr[idx*10 +: 10] = addr;
    req_fn[idx*16 +: 16] = fn;
    req_wdata[idx*32 +: 32] = wd;
    req_be[idx*4 +: 4] = be;
  endtask

  task automatic issue(input vec_t v);
    int n;
    logic started, finished;
    core_en = 1'b1;
    core_lat = v.lat;
    core_rdata = v.rd;
    set_fields(v.idx, v.w, v.addr, v.fn, v.wd, v.be);
    req_valid[v.idx] = 1'b1;
    exp_q.push_back(pack_exp(2'b01 << v.idx, 1'b0, v.exp_rdata, v.lat, v.w));
    started = 0;
    n = 0;
    while (!started && n < 50) begin
      @(negedge user_clk);
      n++;
      started = if0.cfg_mgmt_read || if0.cfg_mgmt_write;
    end
    check("cmd_start", 64'(started), 1);
    if (started) begin
      check("cmd_latency", 64'(n), 1);
      check("grant", 64'(grant), 64'(2'b01 << v.idx));
      check("cmd_addr", 64'(if0.cfg_mgmt_addr), 64'(v.addr));
      check("cmd_fn", 64'(if0.cfg_mgmt_function_number), 64'(v.fn));
      check("cmd_wdata", 64'(if0.cfg_mgmt_write_data), 64'(v.wd));
      check("cmd_be", 64'(if0.cfg_mgmt_byte_enable), 64'(v.be));
      // The arbiter must ignore everything the requester does after grant.
      set_fields(v.idx, ~v.w, 10'($urandom), 16'($urandom), $urandom, 4'($urandom));
      if (v.drop_early) req_valid[v.idx] = 1'b0;
      finished = 0;
      n = 0;
      while (!finished && n < v.lat + 20) begin
        @(negedge user_clk);
        n++;
        finished = req_done[v.idx];
      end
      check("done_seen", 64'(finished), 1);
    end
    req_valid[v.idx] = 1'b0;
    @(negedge user_clk);
    check("sb_drained", 64'(exp_q.size()), 0);
    exp_q.delete();
  endtask

  task automatic issue1(input logic [2:0] mask, input logic [2:0] expg);
    int n;
    v1 = v1 | mask;
    n = 0;
    while (grant1 == 0 && n < 20) begin
      @(negedge user_clk);
      n++;
    end
    check("wrap_grant", 64'(grant1), 64'(expg));
    n = 0;
    while (done1 == 0 && n < 20) begin
      @(negedge user_clk);
      n++;
    end
    check("wrap_done", 64'(done1), 64'(expg));
    v1 = v1 & ~expg;
    @(negedge user_clk);
  endtask

  // ---------------- main sequence ----------------
  vec_t tbl[8];

  initial begin
    int n;
    int seen;
    vec_t v;

    tbl[0] = '{0, 1'b0, 10'h004, 16'h0000, 32'h0,          4'hF, 5, 32'h1234_5678, 1'b0, 32'h1234_5678};
    tbl[1] = '{1, 1'b1, 10'h006, 16'h0000, 32'h0001_0203, 4'hF, 3, 32'hCAFE_F00D, 1'b0, 32'h0};
    tbl[2] = '{0, 1'b0, 10'h3FF, 16'hFFFF, 32'hFFFF_FFFF, 4'h0, 1, 32'h8000_0001, 1'b0, 32'h8000_0001};
    tbl[3] = '{1, 1'b0, 10'h000, 16'h0001, 32'h0,          4'h3, 2, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF};
    for (int i = 4; i < 8; i++) begin
      tbl[i].idx = $urandom_range(0, 1);
      tbl[i].w = 1'($urandom_range(0, 1));
      tbl[i].addr = 10'($urandom);
      tbl[i].fn = 16'($urandom);
      tbl[i].wd = $urandom;
      tbl[i].be = 4'($urandom);
      tbl[i].lat = $urandom_range(1, 8);
      tbl[i].rd = $urandom;
      tbl[i].drop_early = 1'($urandom_range(0, 1));
      tbl[i].exp_rdata = tbl[i].w ? 32'h0 : tbl[i].rd;
    end

    // Reset values, sampled while reset is held.
    repeat (2) @(negedge user_clk);
    check("rst_state", 64'(state0), 64'(IDLE));
    check("rst_grant", 64'(grant), 0);
    check("rst_done", 64'(req_done), 0);
    check("rst_rdata", 64'(req_read_data), 0);
    check("rst_err", 64'(req_error), 0);
    check("rst_cmd", 64'({if0.cfg_mgmt_read, if0.cfg_mgmt_write, if0.cfg_mgmt_debug_access}), 0);
    check("rst_fields", 64'(|{if0.cfg_mgmt_addr, if0.cfg_mgmt_function_number,
                              if0.cfg_mgmt_write_data, if0.cfg_mgmt_byte_enable}), 0);
    user_reset = 1'b0;
    @(negedge user_clk);

    // A core done while idle must be ignored.
    stray_done = 1'b1;
    repeat (2) @(negedge user_clk);
    check("stray_state", 64'(state0), 64'(IDLE));
    check("stray_grant", 64'(grant), 0);
    stray_done = 1'b0;
    @(negedge user_clk);
    check("stray_done", 64'(req_done), 0);

    for (int i = 0; i < 8; i++) issue(tbl[i]);

    // Contention: both requesters held valid for four accesses.
    do_reset();
    core_en = 1'b1;
    core_lat = 3;
    core_rdata = 32'h5555_AAAA;
    set_fields(0, 1'b0, 10'h010, 16'h0002, 32'h0, 4'hF);
    set_fields(1, 1'b1, 10'h020, 16'h0003, 32'h0BAD_F00D, 4'hC);
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(pack_exp(2'b01, 1'b0, 32'h5555_AAAA, 3, 1'b0));
      exp_q.push_back(pack_exp(2'b10, 1'b0, 32'h0, 3, 1'b1));
    end
    req_valid = 2'b11;
    n = 0;
    seen = 0;
    while (seen < 4 && n < 100) begin
      @(negedge user_clk);
      n++;
      if (req_done != 0) seen++;
    end
    req_valid = '0;
    check("contention_count", 64'(seen), 4);
    @(negedge user_clk);
    check("contention_drained", 64'(exp_q.size()), 0);
    exp_q.delete();

    // Reset two cycles into a read.
    core_en = 1'b1;
    core_lat = 4;
    core_rdata = 32'h7777_0000;
    set_fields(0, 1'b0, 10'h055, 16'h0000, 32'h0, 4'hF);
    req_valid[0] = 1'b1;
    n = 0;
    while (!if0.cfg_mgmt_read && n < 20) begin
      @(negedge user_clk);
      n++;
    end
    check("rstmid_start", 64'(if0.cfg_mgmt_read), 1);
    @(negedge user_clk);
    user_reset = 1'b1;
    @(negedge user_clk);
    check("rstmid_cmd", 64'({if0.cfg_mgmt_read, if0.cfg_mgmt_write}), 0);
    check("rstmid_grant", 64'(grant), 0);
    check("rstmid_state", 64'(state0), 64'(IDLE));
    check("rstmid_done", 64'(req_done), 0);
    req_valid = '0;
    user_reset = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge user_clk);
      if (req_done != 0) seen++;
    end
    check("rstmid_no_done", 64'(seen), 0);
    issue(tbl[0]);

`ifdef CFG_MGMT_ARB_TIMEOUT_EN
    // No done from the core: abort after TO cycles of command.
    core_en = 1'b0;
    set_fields(1, 1'b0, 10'h100, 16'h0000, 32'h0, 4'hF);
    exp_q.push_back(pack_exp(2'b10, 1'b1, 32'hFFFF_FFFF, TO, 1'b0));
    req_valid[1] = 1'b1;
    n = 0;
    while (req_done[1] != 1'b1 && n < 60) begin
      @(negedge user_clk);
      n++;
    end
    check("timeout_done", 64'(req_done[1]), 1);
    req_valid = '0;
    @(negedge user_clk);
    check("timeout_drained", 64'(exp_q.size()), 0);
    exp_q.delete();
    // Done arriving in the expiry cycle completes normally.
    v = '{1, 1'b0, 10'h101, 16'h0000, 32'h0, 4'hF, TO, 32'h600D_DA7A, 1'b0, 32'h600D_DA7A};
    issue(v);
`endif

    // Round-robin wrap on the three-requester instance.
    do_reset();
    issue1(3'b100, 3'b100);
    issue1(3'b011, 3'b001);
    issue1(3'b000, 3'b010);

    repeat (3) @(negedge user_clk);
    check("final_sb_empty", 64'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
